wb_resp_stream_bridge: RTL and testbench

- Wishbone classic responder (slave) sitting on the far end of the TT-pin wishbone master bus: 14-bit word address, 32-bit data, per-byte SEL.
- Provides an ID register, a scratch register, a control/status register, and two byte-stream FIFOs.
- TX FIFO: bus writes go in, and a downstream consumer (USB endpoint logic) drains it over valid/ready.
- RX FIFO: an upstream producer fills it over valid/ready, and bus reads pop it.

---
 rtl/wb_resp_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/wb_resp_stream_bridge.sv | 154 +++++++++++++++
 tb/tb_wb_resp_stream_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_resp_pkg.sv
// Shared constants for the wishbone responder / byte-stream bridge:
// register word addresses, CTRL/STATUS bit positions and FSM encoding.
package wb_resp_pkg;

    localparam logic [13:0] ADR_ID      = 14'h0000;
    localparam logic [13:0] ADR_SCRATCH = 14'h0001;
    localparam logic [13:0] ADR_CTRL    = 14'h0002;
    localparam logic [13:0] ADR_STATUS  = 14'h0003;
    localparam logic [13:0] ADR_FIFO    = 14'h0004;

    localparam int unsigned CTRL_TX_FLUSH = 0;
    localparam int unsigned CTRL_RX_FLUSH = 1;

    localparam int unsigned STAT_TX_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL  = 1;
    localparam int unsigned STAT_RX_EMPTY = 2;
    localparam int unsigned STAT_RX_FULL  = 3;
    localparam int unsigned STAT_TX_OVF   = 4;
    localparam int unsigned STAT_RX_OVF   = 5;
    localparam int unsigned STAT_RX_UDF   = 6;
    localparam int unsigned STAT_TX_LVL   = 8;
    localparam int unsigned STAT_RX_LVL   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level output, flush and an overflow pulse.
// Full/empty come from the pre-edge level; flush beats push and pop.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    // A push discarded by flush is not an overflow.
    assign overflow = push & full & ~flush;
    assign level    = count_q;
    assign dout     = mem[rd_ptr_q];

    // Pointer and level update; push+pop together leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_resp_stream_bridge.sv
// Wishbone classic responder exposing ID, SCRATCH, CTRL, STATUS and a
// FIFO window onto a TX byte stream (bus -> consumer) and an RX byte
// stream (producer -> bus). Every strobe is acked exactly once.
module wb_resp_stream_bridge
    import wb_resp_pkg::*;
#(
    parameter int unsigned FIFO_AW  = 3,
    parameter logic [31:0] ID_VALUE = 32'h5442_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_CYC,
    input  logic        wb_STB,
    input  logic        wb_WE,
    input  logic [3:0]  wb_SEL,
    input  logic [13:0] wb_ADR,
    input  logic [31:0] wb_DAT_MOSI,
    output logic [31:0] wb_DAT_MISO,
    output logic        wb_ACK,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    state_t        state_q, state_d;
    logic          access;
    logic          wr_access;
    logic          rd_access;
    logic [31:0]   rd_data;
    logic [31:0]   status_word;
    logic [31:0]   scratch_q, scratch_d;
    logic [2:0]    sticky_q, sticky_d;
    logic [2:0]    sticky_set, sticky_clr;

    logic          tx_push, tx_flush, tx_empty, tx_full, tx_ovf;
    logic [7:0]    tx_dout;
    logic [FIFO_AW:0] tx_level;
    logic          rx_push, rx_pop, rx_flush, rx_empty, rx_full, rx_ovf;
    logic [7:0]    rx_dout;
    logic [FIFO_AW:0] rx_level;

    // A transfer is taken only from IDLE so a lingering STB is not re-acked.
    assign access    = (state_q == ST_IDLE) & wb_CYC & wb_STB;
    assign wr_access = access & wb_WE;
    assign rd_access = access & ~wb_WE;

    assign tx_push  = wr_access & (wb_ADR == ADR_FIFO) & wb_SEL[0];
    assign tx_flush = wr_access & (wb_ADR == ADR_CTRL) & wb_SEL[0] & wb_DAT_MOSI[CTRL_TX_FLUSH];
    assign rx_flush = wr_access & (wb_ADR == ADR_CTRL) & wb_SEL[0] & wb_DAT_MOSI[CTRL_RX_FLUSH];
    assign rx_pop   = rd_access & (wb_ADR == ADR_FIFO);
    assign rx_push  = rx_valid & rx_ready;

    assign tx_data  = tx_dout;
    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .pop      (tx_ready),
        .flush    (tx_flush),
        .din      (wb_DAT_MOSI[7:0]),
        .dout     (tx_dout),
        .empty    (tx_empty),
        .full     (tx_full),
        .level    (tx_level),
        .overflow (tx_ovf)
    );

    sync_fifo #(.DW(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .pop      (rx_pop),
        .flush    (rx_flush),
        .din      (rx_data),
        .dout     (rx_dout),
        .empty    (rx_empty),
        .full     (rx_full),
        .level    (rx_level),
        .overflow (rx_ovf)
    );

    // Next-state: hold until the master drops STB or CYC.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (wb_CYC && wb_STB) state_d = ST_HOLD;
            ST_HOLD: if (!wb_STB || !wb_CYC) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // STATUS word assembly and read-data mux.
    always_comb begin
        status_word = '0;
        status_word[STAT_TX_EMPTY] = tx_empty;
        status_word[STAT_TX_FULL]  = tx_full;
        status_word[STAT_RX_EMPTY] = rx_empty;
        status_word[STAT_RX_FULL]  = rx_full;
        status_word[STAT_TX_OVF]   = sticky_q[0];
        status_word[STAT_RX_OVF]   = sticky_q[1];
        status_word[STAT_RX_UDF]   = sticky_q[2];
        status_word[STAT_TX_LVL +: 8] = 8'(tx_level);
        status_word[STAT_RX_LVL +: 8] = 8'(rx_level);

        rd_data = '0;
        case (wb_ADR)
            ADR_ID:      rd_data = ID_VALUE;
            ADR_SCRATCH: rd_data = scratch_q;
            ADR_STATUS:  rd_data = status_word;
            ADR_FIFO:    rd_data = rx_empty ? 32'h0 : {1'b1, 23'b0, rx_dout};
            default:     rd_data = '0;
        endcase
    end

    // SCRATCH lane writes and sticky set/W1C; set beats clear.
    always_comb begin
        scratch_d = scratch_q;
        if (wr_access && wb_ADR == ADR_SCRATCH) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_SEL[i]) scratch_d[8*i +: 8] = wb_DAT_MOSI[8*i +: 8];
            end
        end
        sticky_set = {rx_pop & rx_empty, rx_ovf, tx_ovf};
        sticky_clr = '0;
        if (wr_access && wb_ADR == ADR_STATUS && wb_SEL[0]) begin
            sticky_clr = wb_DAT_MOSI[STAT_RX_UDF:STAT_TX_OVF];
        end
        sticky_d = (sticky_q & ~sticky_clr) | sticky_set;
    end

    // Bus-side state: FSM, one-cycle ACK, registered read data, registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wb_ACK      <= 1'b0;
            wb_DAT_MISO <= '0;
            scratch_q   <= '0;
            sticky_q    <= '0;
        end else begin
            state_q   <= state_d;
            wb_ACK    <= access;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            if (rd_access) wb_DAT_MISO <= rd_data;
        end
    end

endmodule

// File: tb/tb_wb_resp_stream_bridge.sv
// Scoreboard bench for wb_resp_stream_bridge: bus tasks queue expected
// responses, independent monitors compare on ACK and on TX handshakes.
module tb_wb_resp_stream_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_CYC, wb_STB, wb_WE;
    logic [3:0]  wb_SEL;
    logic [13:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [31:0] wb_DAT_MISO;
    logic        wb_ACK;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    typedef struct {
        bit          is_read;
        logic [31:0] exp;
        string       name;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] tx_q[$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    wb_resp_stream_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .wb_CYC      (wb_CYC),
        .wb_STB      (wb_STB),
        .wb_WE       (wb_WE),
        .wb_SEL      (wb_SEL),
        .wb_ADR      (wb_ADR),
        .wb_DAT_MOSI (wb_DAT_MOSI),
        .wb_DAT_MISO (wb_DAT_MISO),
        .wb_ACK      (wb_ACK),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: every ACK consumes one queued transfer; reads compare data.
    always @(negedge clk) begin : bus_mon
        bus_exp_t e;
        if (wb_ACK === 1'b1) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with no transfer pending, required none");
            end else begin
                e = bus_q.pop_front();
                if (e.is_read) check(e.name, wb_DAT_MISO, e.exp);
            end
        end
    end

    // TX monitor: every consumer handshake must match the next expected byte.
    always @(negedge clk) begin : tx_mon
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: got byte 0x%02h, required no byte", tx_data);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
            end
        end
    end

    // One classic transfer, starting #1 after a rising edge, ending the same way.
    task automatic bus(input logic we, input logic [13:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp, input string name,
                       input bit hold_extra);
        bus_exp_t e;
        e.is_read = !we;
        e.exp     = exp;
        e.name    = name;
        bus_q.push_back(e);
        wb_CYC = 1'b1; wb_STB = 1'b1; wb_WE = we;
        wb_ADR = adr; wb_DAT_MOSI = dat; wb_SEL = sel;
        @(posedge clk); #1;
        check({name, "_ack"}, 32'(wb_ACK), 32'd1);
        if (hold_extra) begin
            @(posedge clk); #1;
            check({name, "_no_second_ack"}, 32'(wb_ACK), 32'd0);
        end
        wb_CYC = 1'b0; wb_STB = 1'b0; wb_WE = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [13:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string name);
        bus(1'b1, adr, dat, sel, 32'h0, name, 1'b0);
    endtask

    task automatic rd(input logic [13:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, 4'hF, exp, name, 1'b0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus_exp_t e;
        int k;
        rst = 1'b1;
        wb_CYC = 0; wb_STB = 0; wb_WE = 0; wb_SEL = 0; wb_ADR = 0; wb_DAT_MOSI = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ack", 32'(wb_ACK), 32'd0);
        check("rst_miso", wb_DAT_MISO, 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        rd(14'h0003, 32'h0000_0005, "rst_status");

        // ID read with STB held one cycle past ACK.
        bus(1'b0, 14'h0000, 32'h0, 4'hF, 32'h5442_0001, "id_read", 1'b1);

        // SCRATCH lane write.
        wr(14'h0001, 32'hAABB_CCDD, 4'b0101, "scratch_wr");
        rd(14'h0001, 32'h00BB_00DD, "scratch_rd");

        // Unmapped and CTRL reads give 0; unmapped write has no effect.
        wr(14'h0010, 32'hFFFF_FFFF, 4'hF, "unmapped_wr");
        rd(14'h0005, 32'h0, "unmapped_rd");
        rd(14'h3FFF, 32'h0, "unmapped_top_rd");
        rd(14'h0002, 32'h0, "ctrl_rd");

        // TX fill past full with the consumer stalled.
        wr(14'h0004, 32'h0000_0077, 4'b1110, "tx_sel0_low");
        for (int i = 1; i <= 9; i++) begin
            wr(14'h0004, 32'(i), 4'b0001, "tx_push");
            if (i <= 8) tx_q.push_back(8'(i));
        end
        rd(14'h0003, 32'h0000_0816, "status_tx_full");
        check("tx_head_stable", {24'h0, tx_data}, 32'h01);
        tx_ready = 1'b1;
        k = 0;
        while (tx_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        tx_ready = 1'b0;
        check("tx_drained_valid", 32'(tx_valid), 32'd0);
        check("tx_drained_count", 32'(tx_q.size()), 32'd0);
        rd(14'h0003, 32'h0000_0015, "status_tx_ovf");
        wr(14'h0003, 32'h0000_0010, 4'hF, "w1c_tx_ovf");
        rd(14'h0003, 32'h0000_0005, "status_after_w1c");

        // RX stream in, bus reads out, then underflow.
        rx_valid = 1'b1; rx_data = 8'h5A;
        @(posedge clk); #1;
        rx_data = 8'hA5;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("rx_ready_level2", 32'(rx_ready), 32'd1);
        rd(14'h0003, 32'h0002_0001, "status_rx_level2");
        rd(14'h0004, 32'h8000_005A, "rx_pop0");
        rd(14'h0004, 32'h8000_00A5, "rx_pop1");
        rd(14'h0004, 32'h0000_0000, "rx_pop_empty");
        rd(14'h0003, 32'h0000_0045, "status_rx_udf");
        wr(14'h0003, 32'h0000_0040, 4'hF, "w1c_rx_udf");
        rd(14'h0003, 32'h0000_0005, "status_udf_clear");

        // TX flush concurrent with a consumer pop.
        wr(14'h0004, 32'h31, 4'b0001, "tx_push_a");
        wr(14'h0004, 32'h32, 4'b0001, "tx_push_b");
        wr(14'h0004, 32'h33, 4'b0001, "tx_push_c");
        rd(14'h0003, 32'h0000_0304, "status_tx_level3");
        check("tx_head_31", {24'h0, tx_data}, 32'h31);
        tx_q.push_back(8'h31);
        tx_ready = 1'b1;
        wr(14'h0002, 32'h0000_0001, 4'hF, "tx_flush");
        tx_ready = 1'b0;
        check("tx_valid_after_flush", 32'(tx_valid), 32'd0);
        rd(14'h0003, 32'h0000_0005, "status_after_flush");

        // Reset while in HOLD with STB still high.
        e.is_read = 1'b1; e.exp = 32'h00BB_00DD; e.name = "hold_pre_rst";
        bus_q.push_back(e);
        wb_CYC = 1'b1; wb_STB = 1'b1; wb_WE = 1'b0; wb_ADR = 14'h0001; wb_SEL = 4'hF;
        @(posedge clk); #1;
        check("hold_pre_rst_ack", 32'(wb_ACK), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_in_hold_ack", 32'(wb_ACK), 32'd0);
        e.is_read = 1'b1; e.exp = 32'h0; e.name = "fresh_after_rst";
        bus_q.push_back(e);
        rst = 1'b0;
        @(posedge clk); #1;
        check("fresh_after_rst_ack", 32'(wb_ACK), 32'd1);
        @(posedge clk); #1;
        check("fresh_no_second_ack", 32'(wb_ACK), 32'd0);
        wb_CYC = 1'b0; wb_STB = 1'b0;
        @(posedge clk); #1;
        rd(14'h0001, 32'h0, "scratch_after_rst");

        repeat (2) @(posedge clk);
        #1;
        check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        check("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
